// File: rtl/ili_init_seq.sv
// ILI panel power-up sequencer: optional hardware reset, then walks a fixed command/data/delay ROM.
// Build option: define ILI_INIT_HWRST_EN to include the HWRST/HWWAIT hardware-reset handshake.
module ili_init_seq #(
  parameter int unsigned DELAY_UNIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  output logic       o_reset_ena,
  output logic       o_reset_val,
  input  logic       i_reset_sent,
  output logic       o_tx_valid,
  output logic       o_tx_dc,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned PTR_W   = 4;
  localparam int unsigned CNT_MAX = 255 * DELAY_UNIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] T_CMD = 2'b00;
  localparam logic [1:0] T_DAT = 2'b01;
  localparam logic [1:0] T_DLY = 2'b10;
  localparam logic [1:0] T_END = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HWRST,
    S_HWWAIT,
    S_FETCH,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_valid_q;
  logic             tx_dc_q;
  logic [7:0]       tx_data_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       rom_type;
  logic [7:0]       rom_payload;
  logic [CNT_W-1:0] dly_cycles;

  // Init ROM: entries past the table read as END.
  always_comb begin
    rom_type    = T_END;
    rom_payload = 8'h00;
    case (ptr_q)
      4'd0:    begin rom_type = T_CMD; rom_payload = 8'h01; end
      4'd1:    begin rom_type = T_DLY; rom_payload = 8'd5;   end
      4'd2:    begin rom_type = T_CMD; rom_payload = 8'h11; end
      4'd3:    begin rom_type = T_DLY; rom_payload = 8'd120; end
      4'd4:    begin rom_type = T_CMD; rom_payload = 8'h3A; end
      4'd5:    begin rom_type = T_DAT; rom_payload = 8'h55; end
      4'd6:    begin rom_type = T_CMD; rom_payload = 8'h36; end
      4'd7:    begin rom_type = T_DAT; rom_payload = 8'h48; end
      4'd8:    begin rom_type = T_CMD; rom_payload = 8'h29; end
      4'd9:    begin rom_type = T_END; rom_payload = 8'h00; end
      default: begin rom_type = T_END; rom_payload = 8'h00; end
    endcase
  end

  assign dly_cycles = CNT_W'(rom_payload) * CNT_W'(DELAY_UNIT_CYC);

`ifdef ILI_INIT_HWRST_EN
  logic reset_ena_q;

  assign o_reset_ena = reset_ena_q;
  assign o_reset_val = 1'b0;
`else
  logic unused_reset_sent;

  assign unused_reset_sent = i_reset_sent;
  assign o_reset_ena       = 1'b0;
  assign o_reset_val       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_dc_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ILI_INIT_HWRST_EN
      reset_ena_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            busy_q <= 1'b1;
            ptr_q  <= '0;
`ifdef ILI_INIT_HWRST_EN
            state_q     <= S_HWRST;
            reset_ena_q <= 1'b1;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef ILI_INIT_HWRST_EN
        S_HWRST: begin
          state_q     <= S_HWWAIT;
          reset_ena_q <= 1'b0;
        end
        S_HWWAIT: begin
          if (i_reset_sent) begin
            state_q <= S_FETCH;
            ptr_q   <= '0;
          end
        end
`endif
        S_FETCH: begin
          case (rom_type)
            T_CMD, T_DAT: begin
              state_q    <= S_SEND;
              tx_valid_q <= 1'b1;
              tx_dc_q    <= rom_type[0];
              tx_data_q  <= rom_payload;
            end
            T_DLY: begin
              // Zero-length delays still occupy one DELAY cycle.
              state_q <= S_DELAY;
              cnt_q   <= (dly_cycles == '0) ? '0 : dly_cycles - CNT_W'(1);
            end
            default: begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          endcase
        end
        S_SEND: begin
          if (i_tx_ready) begin
            state_q    <= S_FETCH;
            tx_valid_q <= 1'b0;
            ptr_q      <= ptr_q + PTR_W'(1);
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) begin
            state_q <= S_FETCH;
            ptr_q   <= ptr_q + PTR_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_valid = tx_valid_q;
  assign o_tx_dc    = tx_dc_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
